// File: rtl/ram_table_player_if.sv
// Port-B bus between the table player and the block RAM read port.
interface ram_table_player_if #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8
);
    logic [ADDR_BITS-1:0] ram_addr;
    logic                 ram_clken;
    logic [DATA_BITS-1:0] ram_data;
    logic                 ram_uflag;

    modport master (output ram_addr, output ram_clken, input ram_data, input ram_uflag);
    modport slave  (input ram_addr, input ram_clken, output ram_data, output ram_uflag);
endinterface

// File: rtl/ram_table_player.sv
// Steps an address window on the RAM read port at a programmable rate and
// turns the returned words into a valid-strobed stream (one-shot or looping).
module ram_table_player #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DIV_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_loop_en,
    input  logic [ADDR_BITS-1:0] i_start_addr,
    input  logic [ADDR_BITS-1:0] i_last_addr,
    input  logic [DIV_BITS-1:0]  i_period,
    ram_table_player_if.master   io_ram,
    output logic [DATA_BITS-1:0] o_data_out,
    output logic                 o_data_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_wrap
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t               r_state, w_state_nxt;

    logic [ADDR_BITS-1:0] r_addr, w_addr_nxt;
    logic [ADDR_BITS-1:0] r_first, w_first_nxt;
    logic [ADDR_BITS-1:0] r_last, w_last_nxt;
    logic [DIV_BITS-1:0]  r_period, w_period_nxt;
    logic [DIV_BITS-1:0]  r_div, w_div_nxt;
    logic                 r_wrap_pend, w_wrap_pend_nxt;
    logic [ADDR_BITS-1:0] r_ram_addr, w_ram_addr_nxt;
    logic                 r_ram_clken, w_ram_clken_nxt;
    logic [DATA_BITS-1:0] r_data_out, w_data_out_nxt;
    logic                 r_data_valid, w_data_valid_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_wrap, w_wrap_nxt;

    logic                 w_accept;
    logic                 w_issue;
    logic                 w_at_last;
    logic [ADDR_BITS-1:0] w_cur_addr;
    logic [ADDR_BITS-1:0] w_end_addr;
    logic [ADDR_BITS-1:0] w_win_first;
    logic [DIV_BITS-1:0]  w_reload;

    // An accepted start issues the first read on the same edge, so the
    // window parameters come straight from the inputs in IDLE.
    assign w_accept    = (r_state == S_IDLE) && i_start;
    assign w_issue     = w_accept || ((r_state == S_RUN) && !i_stop && (r_div == '0));
    assign w_cur_addr  = (r_state == S_IDLE) ? i_start_addr : r_addr;
    assign w_end_addr  = (r_state == S_IDLE) ? i_last_addr  : r_last;
    assign w_win_first = (r_state == S_IDLE) ? i_start_addr : r_first;
    assign w_reload    = (r_state == S_IDLE) ? i_period     : r_period;
    assign w_at_last   = (w_cur_addr == w_end_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = (w_at_last && !i_loop_en) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (i_stop)                               w_state_nxt = S_DRAIN;
                else if (w_issue && w_at_last && !i_loop_en) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_ram_clken && !io_ram.ram_uflag) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_addr_nxt       = r_addr;
        w_first_nxt      = r_first;
        w_last_nxt       = r_last;
        w_period_nxt     = r_period;
        w_div_nxt        = r_div;
        w_wrap_pend_nxt  = r_wrap_pend;
        w_ram_addr_nxt   = r_ram_addr;
        w_ram_clken_nxt  = 1'b0;
        w_wrap_nxt       = 1'b0;
        w_data_valid_nxt = io_ram.ram_uflag && (r_state != S_IDLE);
        w_data_out_nxt   = w_data_valid_nxt ? io_ram.ram_data : r_data_out;
        w_done_nxt       = (r_state == S_DRAIN) && !r_ram_clken && !io_ram.ram_uflag;
        w_busy_nxt       = (w_state_nxt != S_IDLE);

        if (w_accept) begin
            w_first_nxt  = i_start_addr;
            w_last_nxt   = i_last_addr;
            w_period_nxt = i_period;
        end

        if (w_issue) begin
            w_ram_clken_nxt = 1'b1;
            w_ram_addr_nxt  = w_cur_addr;
            w_div_nxt       = w_reload;
            w_wrap_nxt      = (r_state == S_RUN) && r_wrap_pend;
            w_wrap_pend_nxt = 1'b0;
            if (!w_at_last) begin
                w_addr_nxt = w_cur_addr + ADDR_BITS'(1);
            end else if (i_loop_en) begin
                w_addr_nxt      = w_win_first;
                w_wrap_pend_nxt = 1'b1;
            end
        end else if ((r_state == S_RUN) && !i_stop) begin
            w_div_nxt = r_div - DIV_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_first      <= '0;
            r_last       <= '0;
            r_period     <= '0;
            r_div        <= '0;
            r_wrap_pend  <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_clken  <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_addr       <= w_addr_nxt;
            r_first      <= w_first_nxt;
            r_last       <= w_last_nxt;
            r_period     <= w_period_nxt;
            r_div        <= w_div_nxt;
            r_wrap_pend  <= w_wrap_pend_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_clken  <= w_ram_clken_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_wrap       <= w_wrap_nxt;
        end
    end

    assign io_ram.ram_addr  = r_ram_addr;
    assign io_ram.ram_clken = r_ram_clken;
    assign o_data_out       = r_data_out;
    assign o_data_valid     = r_data_valid;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_wrap           = r_wrap;

endmodule

// File: tb/tb_ram_table_player.sv
// Directed bench for ram_table_player with a behavioural port-B RAM (RAM[i]=i+16).
module tb_ram_table_player;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic       i_loop_en = 1'b0;
    logic [7:0] i_start_addr = '0;
    logic [7:0] i_last_addr = '0;
    logic [15:0] i_period = '0;
    logic [7:0] o_data_out;
    logic       o_data_valid, o_busy, o_done, o_wrap;

    logic [7:0] mem [256];
    logic       tb_uflag = 1'b0;
    logic [7:0] tb_data = '0;

    int n_total = 0;
    int n_bad = 0;

    int cyc;
    int rd_cyc[$], rd_addr[$], rd_wrap[$], dv_cyc[$], dv_dat[$], dn_cyc[$];
    int e_rd_cyc[$], e_rd_addr[$], e_rd_wrap[$], e_dv_cyc[$], e_dv_dat[$], e_dn_cyc[$];
    int busy_lo, busy_hi, wrap_cnt;

    ram_table_player_if #(.ADDR_BITS(8), .DATA_BITS(8)) ram_bus ();

    ram_table_player #(.ADDR_BITS(8), .DATA_BITS(8), .DIV_BITS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_loop_en    (i_loop_en),
        .i_start_addr (i_start_addr),
        .i_last_addr  (i_last_addr),
        .i_period     (i_period),
        .io_ram       (ram_bus),
        .o_data_out   (o_data_out),
        .o_data_valid (o_data_valid),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_wrap       (o_wrap)
    );

    always #5 clk = ~clk;

    // Port-B RAM: data and uflag one cycle after an enabled read; not reset.
    always @(posedge clk) begin
        tb_uflag <= ram_bus.ram_clken;
        if (ram_bus.ram_clken) tb_data <= mem[ram_bus.ram_addr];
    end
    assign ram_bus.ram_uflag = tb_uflag;
    assign ram_bus.ram_data  = tb_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        rd_cyc.delete(); rd_addr.delete(); rd_wrap.delete();
        dv_cyc.delete(); dv_dat.delete(); dn_cyc.delete();
        e_rd_cyc.delete(); e_rd_addr.delete(); e_rd_wrap.delete();
        e_dv_cyc.delete(); e_dv_dat.delete(); e_dn_cyc.delete();
        cyc = 0; busy_lo = -1; busy_hi = -1; wrap_cnt = 0;
    endtask

    // Advance one cycle and log what the DUT shows in the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ram_bus.ram_clken) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(int'(ram_bus.ram_addr));
            rd_wrap.push_back(int'(o_wrap));
        end
        if (o_wrap) wrap_cnt++;
        if (o_data_valid) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(int'(o_data_out));
        end
        if (o_done) dn_cyc.push_back(cyc);
        if (o_busy) begin
            if (busy_lo < 0) busy_lo = cyc;
            busy_hi = cyc;
        end
    endtask

    task automatic run_to(input int last_cyc);
        while (cyc < last_cyc) step();
    endtask

    task automatic do_start(input int sa, input int la, input int per, input logic lp);
        i_start_addr = 8'(sa);
        i_last_addr  = 8'(la);
        i_period     = 16'(per);
        i_loop_en    = lp;
        i_start      = 1'b1;
        clear_log();
        step();
        i_start      = 1'b0;
    endtask

    task automatic exp_rd(input int c, input int a, input int w);
        e_rd_cyc.push_back(c); e_rd_addr.push_back(a); e_rd_wrap.push_back(w);
    endtask

    task automatic exp_dv(input int c, input int d);
        e_dv_cyc.push_back(c); e_dv_dat.push_back(d);
    endtask

    task automatic compare_log(input string tag, input int b_lo, input int b_hi);
        int e_wraps;
        e_wraps = 0;
        chk({tag, " n_rd"}, rd_cyc.size(), e_rd_cyc.size());
        foreach (e_rd_cyc[k]) begin
            e_wraps += e_rd_wrap[k];
            if (k < rd_cyc.size()) begin
                chk($sformatf("%s rd%0d cyc", tag, k), rd_cyc[k], e_rd_cyc[k]);
                chk($sformatf("%s rd%0d addr", tag, k), rd_addr[k], e_rd_addr[k]);
                chk($sformatf("%s rd%0d wrap", tag, k), rd_wrap[k], e_rd_wrap[k]);
            end
        end
        chk({tag, " wrap_cnt"}, wrap_cnt, e_wraps);
        chk({tag, " n_dv"}, dv_cyc.size(), e_dv_cyc.size());
        foreach (e_dv_cyc[k]) begin
            if (k < dv_cyc.size()) begin
                chk($sformatf("%s dv%0d cyc", tag, k), dv_cyc[k], e_dv_cyc[k]);
                chk($sformatf("%s dv%0d data", tag, k), dv_dat[k], e_dv_dat[k]);
            end
        end
        chk({tag, " n_done"}, dn_cyc.size(), e_dn_cyc.size());
        foreach (e_dn_cyc[k]) begin
            if (k < dn_cyc.size()) chk($sformatf("%s done%0d cyc", tag, k), dn_cyc[k], e_dn_cyc[k]);
        end
        chk({tag, " busy_first"}, busy_lo, b_lo);
        chk({tag, " busy_last"}, busy_hi, b_hi);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ram_addr"}, ram_bus.ram_addr, 0);
        chk({tag, " ram_clken"}, ram_bus.ram_clken, 0);
        chk({tag, " data_out"}, o_data_out, 0);
        chk({tag, " data_valid"}, o_data_valid, 0);
        chk({tag, " busy"}, o_busy, 0);
        chk({tag, " done"}, o_done, 0);
        chk({tag, " wrap"}, o_wrap, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);

        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // One-shot, period 0, window 2..5
        do_start(2, 5, 0, 1'b0);
        run_to(12);
        for (int k = 0; k < 4; k++) exp_rd(k + 1, k + 2, 0);
        for (int k = 0; k < 4; k++) exp_dv(k + 3, k + 18);
        e_dn_cyc.push_back(7);
        compare_log("oneshot", 1, 6);
        chk("oneshot hold", o_data_out, 21);

        // Rate divider, period 3, window 0..2
        do_start(0, 2, 3, 1'b0);
        run_to(18);
        for (int k = 0; k < 3; k++) exp_rd(1 + 4 * k, k, 0);
        for (int k = 0; k < 3; k++) exp_dv(3 + 4 * k, 16 + k);
        e_dn_cyc.push_back(12);
        compare_log("period3", 1, 11);

        // Window wrapping through address 0
        do_start(254, 1, 0, 1'b0);
        run_to(12);
        exp_rd(1, 254, 0); exp_rd(2, 255, 0); exp_rd(3, 0, 0); exp_rd(4, 1, 0);
        exp_dv(3, 14); exp_dv(4, 15); exp_dv(5, 16); exp_dv(6, 17);
        e_dn_cyc.push_back(7);
        compare_log("addrwrap", 1, 6);

        // Looping, loop_en dropped during the second pass
        do_start(0, 2, 0, 1'b1);
        run_to(5);
        i_loop_en = 1'b0;
        run_to(14);
        for (int k = 0; k < 6; k++) exp_rd(k + 1, k % 3, (k == 3) ? 1 : 0);
        for (int k = 0; k < 6; k++) exp_dv(k + 3, 16 + (k % 3));
        e_dn_cyc.push_back(9);
        compare_log("loop", 1, 8);

        // Stop two cycles after the third read; start during DRAIN ignored
        do_start(0, 9, 5, 1'b0);
        run_to(15);
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        i_start_addr = 8'd40;
        i_last_addr  = 8'd41;
        i_period     = 16'd0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        run_to(30);
        exp_rd(1, 0, 0); exp_rd(7, 1, 0); exp_rd(13, 2, 0);
        exp_dv(3, 16); exp_dv(9, 17); exp_dv(15, 18);
        e_dn_cyc.push_back(17);
        compare_log("stop", 1, 16);

        // Single-entry window
        do_start(9, 9, 0, 1'b0);
        run_to(8);
        exp_rd(1, 9, 0);
        exp_dv(3, 25);
        e_dn_cyc.push_back(4);
        compare_log("single", 1, 3);

        // Reset in cycle 2 of a run, then replay
        do_start(3, 7, 0, 1'b0);
        step();
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        #2;
        rst = 1'b0;
        clear_log();
        run_to(8);
        compare_log("postrst", -1, -1);

        do_start(3, 7, 0, 1'b0);
        run_to(12);
        for (int k = 0; k < 5; k++) exp_rd(k + 1, k + 3, 0);
        for (int k = 0; k < 5; k++) exp_dv(k + 3, k + 19);
        e_dn_cyc.push_back(8);
        compare_log("replay", 1, 7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
